// File: rtl/x_latch_pkg.sv
// Shared types and constants for the latch bank and its channels.
package x_latch_pkg;

    // Per-channel storage state.
    typedef enum logic [0:0] {
        HOLD   = 1'b0,
        POISON = 1'b1
    } chan_state_e;

    // Output mode selection.
    localparam int unsigned MODE_REG    = 0;
    localparam int unsigned MODE_TRANSP = 1;

    // Resolution when set and clear are asserted together.
    localparam int unsigned SR_RST_FIRST = 0;
    localparam int unsigned SR_SET_FIRST = 1;

endpackage

// File: rtl/x_latch_chan.sv
// One storage channel: hold/poison FSM, data register, change pulse and
// optional transparent bypass.
module x_latch_chan
    import x_latch_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter logic [WIDTH-1:0] POISON_VAL  = WIDTH'(8'hA5),
    parameter int unsigned      MODE        = MODE_REG,
    parameter int unsigned      SR_PRIORITY = SR_RST_FIRST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ge_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic             viol_i,
    output logic [WIDTH-1:0] q_o,
    output logic             chg_o,
    output logic             poisoned_o
);

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             chg_q;
    logic             clr_win;
    logic             set_win;
    logic             bypass;

    // Set/clear arbitration: the losing strobe is simply ignored.
    assign clr_win = clr_i & ((SR_PRIORITY == SR_RST_FIRST) | ~set_i);
    assign set_win = set_i & ~clr_win;

    // State register: storage, FSM state and the change pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= HOLD;
            data_q  <= INIT;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chg_q   <= (data_d != data_q);
        end
    end

    // Next-state logic: set/clear, then violation, then gated load.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (clr_win) begin
            state_d = HOLD;
            data_d  = '0;
        end else if (set_win) begin
            state_d = HOLD;
            data_d  = '1;
        end else if (viol_i) begin
            state_d = POISON;
            data_d  = POISON_VAL;
        end else if ((state_q == HOLD) && ge_i) begin
            data_d = d_i;
        end
    end

    // Output logic: transparent mode passes input through only on a clean gated load.
    always_comb begin
        bypass     = (MODE == MODE_TRANSP) && ge_i && (state_q == HOLD)
                     && !set_i && !clr_i && !viol_i;
        q_o        = bypass ? d_i : data_q;
        chg_o      = chg_q;
        poisoned_o = (state_q == POISON);
    end

endmodule

// File: rtl/x_latch_bank.sv
// Bank of independent latch-emulation channels with poison tracking.
module x_latch_bank
    import x_latch_pkg::*;
#(
    parameter int unsigned      CHANNELS    = 4,
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter logic [WIDTH-1:0] POISON_VAL  = WIDTH'(8'hA5),
    parameter int unsigned      MODE        = MODE_REG,
    parameter int unsigned      SR_PRIORITY = SR_RST_FIRST
) (
    input  logic                      CLK,
    input  logic                      NRST,
    input  logic [CHANNELS-1:0]       GE,
    input  logic [CHANNELS*WIDTH-1:0] I,
    input  logic [CHANNELS-1:0]       SET,
    input  logic [CHANNELS-1:0]       RST,
    input  logic [CHANNELS-1:0]       VIOL,
    output logic [CHANNELS*WIDTH-1:0] O,
    output logic [CHANNELS-1:0]       CHG,
    output logic [CHANNELS-1:0]       POISONED
);

    // Reject degenerate or unknown configurations at elaboration.
    if (CHANNELS < 1) begin : gen_bad_channels
        $error("x_latch_bank: CHANNELS must be >= 1");
    end
    if (WIDTH < 1) begin : gen_bad_width
        $error("x_latch_bank: WIDTH must be >= 1");
    end
    if (MODE > MODE_TRANSP) begin : gen_bad_mode
        $error("x_latch_bank: MODE must be 0 or 1");
    end
    if (SR_PRIORITY > SR_SET_FIRST) begin : gen_bad_sr
        $error("x_latch_bank: SR_PRIORITY must be 0 or 1");
    end

    // One channel instance per slice; channels share only the clock and reset.
    for (genvar c = 0; c < CHANNELS; c++) begin : gen_chan
        x_latch_chan #(
            .WIDTH      (WIDTH),
            .INIT       (INIT),
            .POISON_VAL (POISON_VAL),
            .MODE       (MODE),
            .SR_PRIORITY(SR_PRIORITY)
        ) u_chan (
            .clk_i      (CLK),
            .rst_ni     (NRST),
            .ge_i       (GE[c]),
            .d_i        (I[c*WIDTH +: WIDTH]),
            .set_i      (SET[c]),
            .clr_i      (RST[c]),
            .viol_i     (VIOL[c]),
            .q_o        (O[c*WIDTH +: WIDTH]),
            .chg_o      (CHG[c]),
            .poisoned_o (POISONED[c])
        );
    end

endmodule

// File: tb/tb_x_latch_bank.sv
// Scoreboard bench: a registered/rst-first bank and a transparent/set-first bank
// share one stimulus stream and are checked against a channel-level model.
module tb_x_latch_bank;

    localparam int CH = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic [CH-1:0] ge, set, rst, viol;
    logic [31:0]   i;
    logic [31:0]   o0, o1;
    logic [CH-1:0] chg0, chg1, pois0, pois1;

    x_latch_bank #(
        .CHANNELS(CH), .WIDTH(W), .INIT(8'h00), .POISON_VAL(8'hA5),
        .MODE(0), .SR_PRIORITY(0)
    ) u_dut0 (
        .CLK(clk), .NRST(nrst), .GE(ge), .I(i), .SET(set), .RST(rst), .VIOL(viol),
        .O(o0), .CHG(chg0), .POISONED(pois0)
    );

    x_latch_bank #(
        .CHANNELS(CH), .WIDTH(W), .INIT(8'h00), .POISON_VAL(8'hA5),
        .MODE(1), .SR_PRIORITY(1)
    ) u_dut1 (
        .CLK(clk), .NRST(nrst), .GE(ge), .I(i), .SET(set), .RST(rst), .VIOL(viol),
        .O(o1), .CHG(chg1), .POISONED(pois1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0][31:0] o;
        logic [1:0][3:0]  chg;
        logic [1:0][3:0]  pois;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: per DUT (0 = registered/rst-first, 1 = transparent/set-first), per channel.
    logic [7:0] m_val  [2][CH];
    bit         m_pois [2][CH];
    bit         m_chg  [2][CH];
    bit         model_valid = 1'b0;

    function automatic exp_t make_exp();
        exp_t e;
        bit   pass;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                pass = (d == 1) && ge[c] && !m_pois[d][c] && !set[c] && !rst[c] && !viol[c];
                e.o[d][c*8 +: 8] = pass ? i[c*8 +: 8] : m_val[d][c];
                e.chg[d][c]      = m_chg[d][c];
                e.pois[d][c]     = m_pois[d][c];
            end
        end
        return e;
    endfunction

    task automatic model_edge();
        logic [7:0] nv;
        bit         np, do_clr, do_set;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                if (!nrst) begin
                    m_val[d][c]  = 8'h00;
                    m_pois[d][c] = 1'b0;
                    m_chg[d][c]  = 1'b0;
                end else begin
                    nv = m_val[d][c];
                    np = m_pois[d][c];
                    do_clr = rst[c] && !(set[c] && d == 1);
                    do_set = set[c] && !do_clr;
                    if (do_clr) begin
                        nv = 8'h00; np = 1'b0;
                    end else if (do_set) begin
                        nv = 8'hFF; np = 1'b0;
                    end else if (viol[c]) begin
                        nv = 8'hA5; np = 1'b1;
                    end else if (!np && ge[c]) begin
                        nv = i[c*8 +: 8];
                    end
                    m_chg[d][c]  = (nv != m_val[d][c]);
                    m_val[d][c]  = nv;
                    m_pois[d][c] = np;
                end
            end
        end
        if (!nrst) model_valid = 1'b1;
    endtask

    // Drive one cycle; optionally change I mid-cycle to exercise the bypass path.
    task automatic cycle(input logic n, input logic [3:0] g, input logic [31:0] din,
                         input logic [3:0] s, input logic [3:0] r, input logic [3:0] v,
                         input bit tog, input logic [31:0] din2);
        @(negedge clk);
        nrst = n; ge = g; i = din; set = s; rst = r; viol = v;
        if (model_valid) exp_q.push_back(make_exp());
        #3;
        if (tog) i = din2;
        if (model_valid) exp_q.push_back(make_exp());
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input logic [31:0] din);
        cycle(1'b1, 4'h0, din, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    task automatic check_one();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        cmp("dut0.O",        o0,            e.o[0]);
        cmp("dut0.CHG",      32'(chg0),     32'(e.chg[0]));
        cmp("dut0.POISONED", 32'(pois0),    32'(e.pois[0]));
        cmp("dut1.O",        o1,            e.o[1]);
        cmp("dut1.CHG",      32'(chg1),     32'(e.chg[1]));
        cmp("dut1.POISONED", 32'(pois1),    32'(e.pois[1]));
    endtask

    // Monitor: two sample points per cycle, both clear of the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2 check_one();
            #2 check_one();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] s, r, v;
        nrst = 1'b0; ge = '0; i = '0; set = '0; rst = '0; viol = '0;

        // Reset with every gate open, then release and load all-ones.
        cycle(1'b0, 4'hF, 32'hFFFF_FFFF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        cycle(1'b0, 4'hF, 32'hFFFF_FFFF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        cycle(1'b1, 4'hF, 32'hFFFF_FFFF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        idle(32'h0);

        // Registered load on channel 1, then gate closed with different data.
        cycle(1'b1, 4'b0010, 32'h0000_3C00, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        cycle(1'b1, 4'b0000, 32'h0000_5500, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        idle(32'h0000_5500);

        // Transparent pass-through on channel 0 with a mid-cycle input change.
        cycle(1'b1, 4'b0001, 32'h0000_0012, 4'h0, 4'h0, 4'h0, 1'b1, 32'h0000_0034);
        idle(32'h0000_0099);
        idle(32'h0000_0099);

        // Poison channel 2, attempt a load, then clear it.
        cycle(1'b1, 4'b0000, 32'h0, 4'h0, 4'h0, 4'b0100, 1'b0, 32'h0);
        cycle(1'b1, 4'b0100, 32'h0077_0000, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        cycle(1'b1, 4'b0000, 32'h0, 4'h0, 4'b0100, 4'h0, 1'b0, 32'h0);
        idle(32'h0);

        // Set/clear conflict on channel 3, alone and with a violation.
        cycle(1'b1, 4'b0000, 32'h0, 4'b1000, 4'b1000, 4'h0, 1'b0, 32'h0);
        idle(32'h0);
        cycle(1'b1, 4'b1000, 32'h4200_0000, 4'b1000, 4'b1000, 4'b1000, 1'b0, 32'h0);
        idle(32'h0);

        // Poison channels 0 and 2, then reset in the middle of it.
        cycle(1'b1, 4'b0000, 32'h0, 4'h0, 4'h0, 4'b0101, 1'b0, 32'h0);
        idle(32'h0);
        cycle(1'b0, 4'hF, 32'h1234_5678, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        idle(32'h0);
        idle(32'h0);

        // Random traffic with sparse strobes and rare resets.
        for (int n = 0; n < 400; n++) begin
            s = '0; r = '0; v = '0;
            for (int c = 0; c < CH; c++) begin
                s[c] = ($urandom_range(0, 7) == 0);
                r[c] = ($urandom_range(0, 7) == 0);
                v[c] = ($urandom_range(0, 7) == 0);
            end
            cycle(($urandom_range(0, 31) != 0), 4'($urandom), $urandom, s, r, v,
                  ($urandom_range(0, 3) == 0), $urandom);
        end

        idle(32'h0);
        @(negedge clk);
        #5;
        cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
